wb_regfile_seq: RTL and testbench

WB_REGFILE_SEQ -- requirements
Module: wb_regfile_seq

---
 rtl/wb_regfile_seq.sv | 142 ++++++++++++++
 tb/tb_wb_regfile_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile_seq.sv
// ---------------------------------------------------------------------------
// wb_regfile_seq
//   Write-back stage register file with a second write-back cycle for
//   instructions that write two registers.
//
//   32 x 32-bit registers, R0 is hard-wired to zero. A "double" instruction
//   writes its primary result to WriteReg in the IDLE cycle. Its second result
//   goes to WriteReg+1 (mod 32) in the following SECOND cycle. Stall asks
//   upstream to hold for that extra cycle.
//
//   Ports
//     Clk, Rst_n           clock, asynchronous active-low reset
//     MEMWB_*              MEM/WB pipeline register contents (write request)
//     RdAddrA/B, RdDataA/B combinational read ports with write-through bypass
//     Stall                upstream hold request (combinational)
//     WB_Fwd*              write performed at the coming edge (combinational)
//     RetireCount          number of completed (non-bubble) instructions
//     dbg_state            FSM state: 0 = IDLE, 1 = SECOND
//
//   Handshake: there is no valid/ready pair. Every IDLE cycle accepts the
//   MEM/WB contents. When Stall=1, upstream must hold EX/MEM and present a
//   bubble in the next cycle. All MEMWB_* inputs are ignored in SECOND.
// ---------------------------------------------------------------------------
module wb_regfile_seq (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        MEMWB_MemtoReg,
    input  logic        MEMWB_RegWrite,
    input  logic [31:0] MEMWB_DMReadData,
    input  logic [31:0] MEMWB_ALUResult,
    input  logic [4:0]  MEMWB_WriteReg,
    input  logic        MEMWB_Double,
    input  logic [31:0] MEMWB_ALU2,
    input  logic [31:0] MEMWB_Instr,
    input  logic [4:0]  RdAddrA,
    input  logic [4:0]  RdAddrB,
    output logic [31:0] RdDataA,
    output logic [31:0] RdDataB,
    output logic        Stall,
    output logic        WB_FwdValid,
    output logic [4:0]  WB_FwdReg,
    output logic [31:0] WB_FwdData,
    output logic [31:0] RetireCount,
    output logic        dbg_state
);

    typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] regs_q [32];
    logic [4:0]  pend_reg_q, pend_reg_d;
    logic [31:0] pend_data_q, pend_data_d;
    logic [31:0] retire_q, retire_d;

    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] prim_data;

    assign prim_data = MEMWB_MemtoReg ? MEMWB_DMReadData : MEMWB_ALUResult;

    // State register plus pending-write and retire counters.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            pend_reg_q  <= '0;
            pend_data_q <= '0;
            retire_q    <= '0;
        end else begin
            state_q     <= state_d;
            pend_reg_q  <= pend_reg_d;
            pend_data_q <= pend_data_d;
            retire_q    <= retire_d;
        end
    end

    // Register array. Only one write port, so a single write per cycle.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (WB_FwdValid) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (MEMWB_RegWrite && MEMWB_Double) state_d = SECOND;
            SECOND:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic.
    always_comb begin
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        Stall       = 1'b0;
        pend_reg_d  = pend_reg_q;
        pend_data_d = pend_data_q;
        retire_d    = retire_q;
        case (state_q)
            IDLE: begin
                if (MEMWB_RegWrite) begin
                    wr_en   = 1'b1;
                    wr_addr = MEMWB_WriteReg;
                    wr_data = prim_data;
                    if (MEMWB_Double) begin
                        // 5-bit add: register 31 wraps to R0, whose write is dropped.
                        Stall       = Rst_n;
                        pend_reg_d  = MEMWB_WriteReg + 5'd1;
                        pend_data_d = MEMWB_ALU2;
                    end
                end
                if (MEMWB_Instr != '0) retire_d = retire_q + 32'd1;
            end
            SECOND: begin
                wr_en   = 1'b1;
                wr_addr = pend_reg_q;
                wr_data = pend_data_q;
            end
            default: ;
        endcase
    end

    // Rst_n gating keeps the forward/bypass path quiet while reset is held.
    assign WB_FwdValid = wr_en && (wr_addr != 5'd0) && Rst_n;
    assign WB_FwdReg   = wr_addr;
    assign WB_FwdData  = wr_data;

    assign RdDataA = (WB_FwdValid && (RdAddrA == wr_addr)) ? wr_data :
                     (RdAddrA == 5'd0) ? 32'd0 : regs_q[RdAddrA];
    assign RdDataB = (WB_FwdValid && (RdAddrB == wr_addr)) ? wr_data :
                     (RdAddrB == 5'd0) ? 32'd0 : regs_q[RdAddrB];

    assign RetireCount = retire_q;
    assign dbg_state   = (state_q == SECOND);

endmodule

// File: tb/tb_wb_regfile_seq.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile_seq
//   Bench for wb_regfile_seq. The stimulus process drives one cycle at a time.
//   For each cycle it pushes the expected observable outputs into exp_q. Those
//   values come from a register-array/pending-queue model. A negedge monitor
//   pops exp_q and compares.
// ---------------------------------------------------------------------------
module tb_wb_regfile_seq;

    localparam int EXP_W = 1 + 1 + 5 + 32 + 32 + 32 + 32 + 1;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- DUT signals ----------------
    logic        MEMWB_MemtoReg, MEMWB_RegWrite, MEMWB_Double;
    logic [31:0] MEMWB_DMReadData, MEMWB_ALUResult, MEMWB_ALU2, MEMWB_Instr;
    logic [4:0]  MEMWB_WriteReg, RdAddrA, RdAddrB;
    logic [31:0] RdDataA, RdDataB, WB_FwdData, RetireCount;
    logic        Stall, WB_FwdValid, dbg_state;
    logic [4:0]  WB_FwdReg;

    wb_regfile_seq dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .MEMWB_MemtoReg(MEMWB_MemtoReg), .MEMWB_RegWrite(MEMWB_RegWrite),
        .MEMWB_DMReadData(MEMWB_DMReadData), .MEMWB_ALUResult(MEMWB_ALUResult),
        .MEMWB_WriteReg(MEMWB_WriteReg), .MEMWB_Double(MEMWB_Double),
        .MEMWB_ALU2(MEMWB_ALU2), .MEMWB_Instr(MEMWB_Instr),
        .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
        .RdDataA(RdDataA), .RdDataB(RdDataB),
        .Stall(Stall), .WB_FwdValid(WB_FwdValid), .WB_FwdReg(WB_FwdReg),
        .WB_FwdData(WB_FwdData), .RetireCount(RetireCount),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [31:0] m_regs [32];
    logic [36:0] m_pend[$];   // {register, data} second writes still owed
    logic [31:0] m_retire;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            logic [EXP_W-1:0] e;
            logic        e_st, e_fv, e_state;
            logic [4:0]  e_fr;
            logic [31:0] e_fd, e_a, e_b, e_rc;
            e = exp_q.pop_front();
            {e_st, e_fv, e_fr, e_fd, e_a, e_b, e_rc, e_state} = e;
            chk("stall",       {31'd0, Stall},       {31'd0, e_st});
            chk("fwd_valid",   {31'd0, WB_FwdValid}, {31'd0, e_fv});
            if (e_fv) begin
                chk("fwd_reg",  {27'd0, WB_FwdReg}, {27'd0, e_fr});
                chk("fwd_data", WB_FwdData, e_fd);
            end
            chk("rd_data_a",   RdDataA, e_a);
            chk("rd_data_b",   RdDataB, e_b);
            chk("retire_count", RetireCount, e_rc);
            chk("state",       {31'd0, dbg_state},   {31'd0, e_state});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic rw, input logic m2r, input logic dbl,
                          input logic [4:0] wreg, input logic [31:0] alu,
                          input logic [31:0] alu2, input logic [31:0] dm,
                          input logic [31:0] instr, input logic [4:0] ra,
                          input logic [4:0] rb);
        MEMWB_RegWrite   = rw;
        MEMWB_MemtoReg   = m2r;
        MEMWB_Double     = dbl;
        MEMWB_WriteReg   = wreg;
        MEMWB_ALUResult  = alu;
        MEMWB_ALU2       = alu2;
        MEMWB_DMReadData = dm;
        MEMWB_Instr      = instr;
        RdAddrA          = ra;
        RdAddrB          = rb;
    endtask

    // One clock cycle: predict outputs for the current inputs, then advance
    // the model across the rising edge.
    task automatic step();
        logic        w, st, fv;
        logic [4:0]  tr;
        logic [31:0] td, ea, eb;
        w = 1'b0; st = 1'b0; tr = '0; td = '0;
        if (!Rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_pend.delete();
            m_retire = '0;
        end else if (m_pend.size() > 0) begin
            w = 1'b1;
            {tr, td} = m_pend[0];
        end else if (MEMWB_RegWrite) begin
            w  = 1'b1;
            tr = MEMWB_WriteReg;
            td = MEMWB_MemtoReg ? MEMWB_DMReadData : MEMWB_ALUResult;
            st = MEMWB_Double;
        end
        fv = w && (tr != 5'd0);
        ea = (fv && RdAddrA == tr) ? td : m_regs[RdAddrA];
        eb = (fv && RdAddrB == tr) ? td : m_regs[RdAddrB];
        exp_q.push_back({st, fv, tr, td, ea, eb, m_retire, (m_pend.size() > 0)});
        @(posedge Clk);
        if (Rst_n) begin
            if (fv) m_regs[tr] = td;
            if (m_pend.size() > 0) begin
                void'(m_pend.pop_front());
            end else begin
                if (MEMWB_RegWrite && MEMWB_Double)
                    m_pend.push_back({5'(tr + 5'd1), MEMWB_ALU2});
                if (MEMWB_Instr != 32'd0) m_retire = m_retire + 32'd1;
            end
        end
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_retire = '0;
        set_in(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        @(posedge Clk);
        #1;

        // Reset held with an active double-write request: outputs stay quiet.
        Rst_n = 1'b0;
        set_in(1'b1, 1'b0, 1'b1, 5'd5, 32'h55, 32'h66, 32'd0, 32'h1, 5'd5, 5'd6);
        step();
        step();

        // Single write, first edge after release.
        Rst_n = 1'b1;
        set_in(1'b1, 1'b0, 1'b0, 5'd5, 32'h1234, 32'd0, 32'd0, 32'h20A51234, 5'd5, 5'd0);
        step();
        set_in(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd5, 5'd0);
        step();

        // Load with same-cycle bypass.
        set_in(1'b1, 1'b1, 1'b0, 5'd7, 32'h0BAD, 32'd0, 32'hDEADBEEF, 32'h8C070000, 5'd7, 5'd5);
        step();
        set_in(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd7, 5'd5);
        step();

        // Double write; a write request during SECOND must be ignored.
        set_in(1'b1, 1'b0, 1'b1, 5'd10, 32'h11, 32'h22, 32'd0, 32'h0000D00B, 5'd10, 5'd11);
        step();
        set_in(1'b1, 1'b0, 1'b0, 5'd12, 32'h55, 32'd0, 32'd0, 32'h12345678, 5'd11, 5'd12);
        step();
        set_in(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd12, 5'd11);
        step();

        // Double write to R31: the second target wraps to R0 and is dropped.
        set_in(1'b1, 1'b0, 1'b1, 5'd31, 32'h77, 32'h99, 32'd0, 32'h1F, 5'd31, 5'd0);
        step();
        set_in(1'b1, 1'b0, 1'b1, 5'd2, 32'hAA, 32'hBB, 32'd0, 32'h2, 5'd0, 5'd31);
        step();
        // Plain write to R0.
        set_in(1'b1, 1'b0, 1'b0, 5'd0, 32'hABC, 32'd0, 32'd0, 32'h3, 5'd0, 5'd31);
        step();
        set_in(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd2);
        step();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            Rst_n = ($urandom_range(0, 49) != 0);
            set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
                   $urandom, $urandom, $urandom,
                   ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom,
                   5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            step();
        end
        Rst_n = 1'b1;

        // Reset while in SECOND aborts the pending write.
        set_in(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        step();
        set_in(1'b1, 1'b0, 1'b1, 5'd3, 32'h33, 32'h44, 32'd0, 32'h5, 5'd3, 5'd4);
        step();
        Rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd4, 5'd3);
        step();
        Rst_n = 1'b1;
        for (int r = 0; r < 32; r += 2) begin
            set_in(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'(r), 5'(r + 1));
            step();
        end

        // Let the monitor consume the last entry.
        @(negedge Clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
